// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operating mode
// encodings and the shift-count width helper.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Bits needed to hold a shift count in the range 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : univ_shift_reg_pkg

// File: rtl/usr_cell.sv
// One bit of the universal shift register: a 4:1 next-state mux feeding a
// flop with clock enable and synchronous active-low reset.
module usr_cell
    import univ_shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] sel,
    input  logic       shr_bit,
    input  logic       shl_bit,
    input  logic       load_bit,
    output logic       q_bit
);

    logic next_s;
    logic q_r;

    // Select the next value of this bit from the operating mode.
    always_comb begin
        next_s = q_r;
        case (sel)
            MODE_HOLD: next_s = q_r;
            MODE_SHR:  next_s = shr_bit;
            MODE_SHL:  next_s = shl_bit;
            MODE_LOAD: next_s = load_bit;
            default:   next_s = q_r;
        endcase
    end

    // Storage flop; reset wins over the enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else if (en) begin
            q_r <= next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q_bit = q_r;

endmodule : usr_cell

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with optional rotation and a saturating shift counter.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int ROTATE = 0,
    localparam int CW     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             full
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] shr_src_s;
    logic [WIDTH-1:0] shl_src_s;
    logic [CW-1:0]    cnt_r;

    // Neighbour wiring; the serial ends come from the opposite end when rotating.
    always_comb begin
        shr_src_s = {1'b0, q_s[WIDTH-1:1]};
        shl_src_s = {q_s[WIDTH-2:0], 1'b0};
        if (ROTATE != 0) begin
            shr_src_s[WIDTH-1] = q_s[0];
            shl_src_s[0]       = q_s[WIDTH-1];
        end else begin
            shr_src_s[WIDTH-1] = sin_r;
            shl_src_s[0]       = sin_l;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_cell u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .sel      (mode),
            .shr_bit  (shr_src_s[i]),
            .shl_bit  (shl_src_s[i]),
            .load_bit (d[i]),
            .q_bit    (q_s[i])
        );
    end

    // Shift counter: cleared by load, saturates at WIDTH instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            case (mode)
                MODE_LOAD: cnt_r <= '0;
                MODE_SHR,
                MODE_SHL:  cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);
                MODE_HOLD: cnt_r <= cnt_r;
                default:   cnt_r <= cnt_r;
            endcase
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign q         = q_s;
    assign q_not     = ~q_s;
    assign sout_r    = q_s[0];
    assign sout_l    = q_s[WIDTH-1];
    assign shift_cnt = cnt_r;
    assign full      = (cnt_r == CNT_MAX);

endmodule : univ_shift_reg
